mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by RV32I (XLEN 32).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 ex_reg  in  ex_mem_regfile  EX/MEM register: valid, opcode, funct3, funct7, rd, alu_out, rs2_out, pc, br_en, u_imm, load_regfile.
REQ-005 dmem_rdata  in  32  data-memory read word.
REQ-006 dmem_resp  in  1  data-memory completion, 1-cycle pulse.
REQ-007 dmem_read  out  1  load request, level, held until dmem_resp.
REQ-008 dmem_write  out  1  store request, level, held until dmem_resp.
REQ-009 dmem_addr  out  32  word-aligned address, {alu_out[31:2],2'b00}.
REQ-010 dmem_wdata  out  32  store data, lane-shifted.
REQ-011 dmem_mbe  out  4  byte-enable mask.
REQ-012 mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 mem_reg  out  mem_wb_regfile  registered MEM/WB payload: ex_reg fields plus mem_rdata (32).

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 IDLE: ex_reg.valid with opcode op_load/op_store and aligned access -> BUSY, mem_stall=1; otherwise stay IDLE, mem_stall=0.
REQ-016 BUSY: dmem_read (load) or dmem_write (store) asserted, mem_stall=1; on dmem_resp latch dmem_rdata into rdata_q and go to DONE.
REQ-017 DONE: mem_stall=0, no request; -> IDLE unconditionally.
REQ-018 dmem_read/dmem_write SHALL be asserted only in BUSY, never together.
REQ-019 mem_reg SHALL load {ex_reg, mem_rdata} on every edge with mem_stall=0; it SHALL hold while mem_stall=1.
REQ-020 mem_rdata SHALL be rdata_q for loads and 0 otherwise; raw word, no extraction (WB extracts using funct3 and alu_out[1:0]).
REQ-021 Latency: non-memory op 1 cycle; memory op = 2 + cycles from request to dmem_resp (minimum 3 when resp arrives in first BUSY cycle).
REQ-022 Store mask: sb 4'b0001<<alu_out[1:0]; sh 4'b0011<<{alu_out[1],1'b0}; sw 4'b1111.
REQ-023 Store data: rs2_out << (8*alu_out[1:0]), truncated to 32 bits; loads drive dmem_mbe 4'b1111.
REQ-024 Misaligned (sh/lh/lhu with alu_out[0]=1, sw/lw with alu_out[1:0]!=0): no request, stay IDLE, pass in 1 cycle with load_regfile cleared in mem_reg.
REQ-025 ex_reg.valid=0 (bubble): no request, mem_reg.valid=0 on next edge.
REQ-026 dmem_resp in IDLE or DONE SHALL be ignored.
REQ-027 dmem_addr/dmem_wdata/dmem_mbe SHALL be stable throughout BUSY (ex_reg held by mem_stall).

Reset
REQ-028 rst=0 at an edge: state IDLE, rdata_q 0, mem_reg all-zero (valid=0, load_regfile=0).
REQ-029 Outputs after reset: dmem_read 0, dmem_write 0, mem_stall 0; addr/wdata/mbe combinational from ex_reg.
REQ-030 Reset in BUSY SHALL abort the access; requests drop the next cycle; a late dmem_resp SHALL be ignored.

Structure
REQ-031 ex_mem_regfile and mem_wb_regfile SHALL live in package regfile; opcode enum and store funct3 codes in rv32i_types.
REQ-032 FSM state enum SHALL be local to the module.
REQ-033 Lane alignment (mbe, wdata, misaligned flag) SHALL be one combinational sub-module, store_align.

Verification
REQ-034 lw, alu_out=0x100, resp after 3 BUSY cycles, rdata=0xDEADBEEF -> dmem_read 3 cycles, addr 0x100, mem_stall 4 cycles, mem_reg.mem_rdata=0xDEADBEEF.
REQ-035 sb, alu_out=0x203, rs2_out=0x000000A5, resp immediate -> dmem_write 1 cycle, addr 0x200, mbe 4'b1000, wdata 0xA5000000.
REQ-036 sh, alu_out=0x301 -> no request, mem_stall 0, mem_reg.load_regfile=0 next edge.
REQ-037 addi rd=5, alu_out=7, then bubble -> mem_reg.rd=5, alu_out=7 after 1 edge; next edge mem_reg.valid=0; no requests.
REQ-038 lw in BUSY, rst=0 one cycle, dmem_resp the following cycle -> dmem_read 0 after reset edge, state IDLE, mem_reg.valid=0, resp ignored.
REQ-039 Back-to-back lw, lw, each resp after 1 cycle -> two BUSY/DONE sequences, one IDLE between, correct rdata in each mem_reg.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// rtl/mem_stage_ctrl_pkg.sv - RV32I opcode/funct3 types and EX/MEM, MEM/WB payloads
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    // funct3[1:0] encodes access size for both loads and stores
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

package regfile;
    import rv32i_types::*;

    typedef struct packed {
        logic        valid;
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [31:0] alu_out;
        logic [31:0] rs2_out;
        logic [31:0] pc;
        logic        br_en;
        logic [31:0] u_imm;
        logic        load_regfile;
    } ex_mem_regfile;

    typedef struct packed {
        logic        valid;
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [31:0] alu_out;
        logic [31:0] rs2_out;
        logic [31:0] pc;
        logic        br_en;
        logic [31:0] u_imm;
        logic        load_regfile;
        logic [31:0] mem_rdata;
    } mem_wb_regfile;

endpackage

// File: rtl/mem_stage_ctrl_store_align.sv
// rtl/mem_stage_ctrl_store_align.sv - byte-lane mask, store data shift and misalignment detect
module store_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2_out,
    output logic [3:0]  mbe,
    output logic [31:0] wdata,
    output logic        misaligned
);

    // Lane placement is purely a function of size and the low address bits
    always_comb begin
        mbe        = 4'b1111;
        wdata      = rs2_out << {addr_lo, 3'b000};
        misaligned = 1'b0;
        case (funct3[1:0])
            SIZE_HALF: misaligned = addr_lo[0];
            SIZE_WORD: misaligned = |addr_lo;
            default:   misaligned = 1'b0;
        endcase
        if (is_store) begin
            case (funct3)
                sb:      mbe = 4'b0001 << addr_lo;
                sh:      mbe = 4'b0011 << {addr_lo[1], 1'b0};
                sw:      mbe = 4'b1111;
                default: mbe = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage: data-memory handshake FSM, stall and MEM/WB register
module mem_stage_ctrl
    import rv32i_types::*;
    import regfile::*;
(
    input  logic          clk,
    input  logic          rst,
    input  ex_mem_regfile ex_reg,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_resp,
    output logic          dmem_read,
    output logic          dmem_write,
    output logic [31:0]   dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_mbe,
    output logic          mem_stall,
    output mem_wb_regfile mem_reg
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   rdata_q, rdata_d;
    mem_wb_regfile mem_reg_q, mem_reg_d;

    logic is_load;
    logic is_store;
    logic misaligned;
    logic start;

    assign is_load   = (ex_reg.opcode == op_load);
    assign is_store  = (ex_reg.opcode == op_store);
    assign dmem_addr = {ex_reg.alu_out[31:2], 2'b00};
    assign mem_reg   = mem_reg_q;

    store_align u_store_align (
        .funct3     (ex_reg.funct3),
        .is_store   (is_store),
        .addr_lo    (ex_reg.alu_out[1:0]),
        .rs2_out    (ex_reg.rs2_out),
        .mbe        (dmem_mbe),
        .wdata      (dmem_wdata),
        .misaligned (misaligned)
    );

    // Only a valid, aligned load/store opens a memory transaction
    assign start = ex_reg.valid && (is_load || is_store) && !misaligned;

    // Handshake FSM: request level held through BUSY, one DONE cycle releases the stall
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        mem_stall  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = BUSY;
                    mem_stall = 1'b1;
                end
            end
            BUSY: begin
                mem_stall  = 1'b1;
                dmem_read  = is_load;
                dmem_write = is_store;
                if (dmem_resp) begin
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MEM/WB payload advances whenever the pipeline is not stalled
    always_comb begin
        mem_reg_d = mem_reg_q;
        if (!mem_stall) begin
            mem_reg_d.valid        = ex_reg.valid;
            mem_reg_d.opcode       = ex_reg.opcode;
            mem_reg_d.funct3       = ex_reg.funct3;
            mem_reg_d.funct7       = ex_reg.funct7;
            mem_reg_d.rd           = ex_reg.rd;
            mem_reg_d.alu_out      = ex_reg.alu_out;
            mem_reg_d.rs2_out      = ex_reg.rs2_out;
            mem_reg_d.pc           = ex_reg.pc;
            mem_reg_d.br_en        = ex_reg.br_en;
            mem_reg_d.u_imm        = ex_reg.u_imm;
            mem_reg_d.load_regfile = ex_reg.load_regfile;
            mem_reg_d.mem_rdata    = (is_load && state_q == DONE) ? rdata_q : 32'h0;
            // A misaligned access is dropped, so it must not write back
            if (ex_reg.valid && (is_load || is_store) && misaligned) begin
                mem_reg_d.load_regfile = 1'b0;
            end
        end
    end

    // State, read-data and MEM/WB registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rdata_q   <= 32'h0;
            mem_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            mem_reg_q <= mem_reg_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
    import rv32i_types::*;
    import regfile::*;

    logic          clk;
    logic          rst;
    ex_mem_regfile ex_reg;
    logic [31:0]   dmem_rdata;
    logic          dmem_resp;
    logic          dmem_read;
    logic          dmem_write;
    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [3:0]    dmem_mbe;
    logic          mem_stall;
    mem_wb_regfile mem_reg;

    int checks = 0;
    int errors = 0;

    int          rd_cnt, wr_cnt, st_cnt;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_mbe;
    logic        a_stable;

    mem_stage_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ex_reg     (ex_reg),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_mbe   (dmem_mbe),
        .mem_stall  (mem_stall),
        .mem_reg    (mem_reg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_mem_regfile mk(input rv32i_opcode op, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [31:0] alu,
                                         input logic [31:0] rs2, input logic lrf);
        ex_mem_regfile e;
        e              = '0;
        e.valid        = 1'b1;
        e.opcode       = op;
        e.funct3       = f3;
        e.rd           = rd;
        e.alu_out      = alu;
        e.rs2_out      = rs2;
        e.pc           = 32'h0000_1000;
        e.load_regfile = lrf;
        return e;
    endfunction

    // Walks one access from IDLE to DONE, answering after resp_after request cycles
    task automatic run_access(input int resp_after, input logic [31:0] rdata,
                              output int rd_n, output int wr_n, output int st_n,
                              output logic [31:0] addr_o, output logic [31:0] wdata_o,
                              output logic [3:0] mbe_o, output logic stable_o);
        int   busy;
        logic done;
        busy = 0; rd_n = 0; wr_n = 0; st_n = 0; done = 1'b0;
        addr_o = '0; wdata_o = '0; mbe_o = '0; stable_o = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (dmem_read)  rd_n++;
            if (dmem_write) wr_n++;
            if (dmem_read && dmem_write) stable_o = 1'b0;
            if (!mem_stall) begin
                done = 1'b1;
                break;
            end
            st_n++;
            if (dmem_read || dmem_write) begin
                busy++;
                if (busy == 1) begin
                    addr_o = dmem_addr; wdata_o = dmem_wdata; mbe_o = dmem_mbe;
                end else if (dmem_addr !== addr_o || dmem_wdata !== wdata_o || dmem_mbe !== mbe_o) begin
                    stable_o = 1'b0;
                end
                if (busy == resp_after) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            tick();
            dmem_resp = 1'b0;
            #1;
        end
        chk("access_completes", {31'b0, done}, 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        ex_reg     = '0;
        dmem_rdata = 32'h0;
        dmem_resp  = 1'b0;
        tick();
        tick();

        // reset state
        ex_reg.alu_out = 32'h0000_0123;
        #1;
        chk("rst_dmem_read",  {31'b0, dmem_read},  32'd0);
        chk("rst_dmem_write", {31'b0, dmem_write}, 32'd0);
        chk("rst_mem_stall",  {31'b0, mem_stall},  32'd0);
        chk("rst_mem_reg_zero", {31'b0, (mem_reg === '0)}, 32'd1);
        chk("rst_addr_comb",  dmem_addr, 32'h0000_0120);
        rst = 1'b1;
        tick();

        // lw, response in third BUSY cycle
        ex_reg = mk(op_load, 3'b010, 5'd3, 32'h0000_0100, 32'h0, 1'b1);
        #1;
        run_access(3, 32'hDEAD_BEEF, rd_cnt, wr_cnt, st_cnt, a_addr, a_wdata, a_mbe, a_stable);
        chk("lw_read_cycles",  rd_cnt, 32'd3);
        chk("lw_write_cycles", wr_cnt, 32'd0);
        chk("lw_stall_cycles", st_cnt, 32'd4);
        chk("lw_addr",   a_addr, 32'h0000_0100);
        chk("lw_mbe",    {28'b0, a_mbe}, 32'h0000_000F);
        chk("lw_stable", {31'b0, a_stable}, 32'd1);
        tick();
        chk("lw_mem_rdata", mem_reg.mem_rdata, 32'hDEAD_BEEF);
        chk("lw_valid", {31'b0, mem_reg.valid}, 32'd1);
        chk("lw_rd", {27'b0, mem_reg.rd}, 32'd3);
        chk("lw_load_regfile", {31'b0, mem_reg.load_regfile}, 32'd1);

        // sb at byte 3, immediate response
        ex_reg = mk(op_store, 3'b000, 5'd0, 32'h0000_0203, 32'h0000_00A5, 1'b0);
        #1;
        run_access(1, 32'h0, rd_cnt, wr_cnt, st_cnt, a_addr, a_wdata, a_mbe, a_stable);
        chk("sb_write_cycles", wr_cnt, 32'd1);
        chk("sb_read_cycles",  rd_cnt, 32'd0);
        chk("sb_stall_cycles", st_cnt, 32'd2);
        chk("sb_addr",  a_addr, 32'h0000_0200);
        chk("sb_mbe",   {28'b0, a_mbe}, 32'h0000_0008);
        chk("sb_wdata", a_wdata, 32'hA500_0000);
        tick();
        chk("sb_valid", {31'b0, mem_reg.valid}, 32'd1);
        chk("sb_mem_rdata", mem_reg.mem_rdata, 32'h0);

        // aligned sh in upper half, response after two cycles
        ex_reg = mk(op_store, 3'b001, 5'd0, 32'h0000_0202, 32'h1234_5678, 1'b0);
        #1;
        run_access(2, 32'h0, rd_cnt, wr_cnt, st_cnt, a_addr, a_wdata, a_mbe, a_stable);
        chk("sh_write_cycles", wr_cnt, 32'd2);
        chk("sh_mbe",   {28'b0, a_mbe}, 32'h0000_000C);
        chk("sh_wdata", a_wdata, 32'h5678_0000);
        chk("sh_stable", {31'b0, a_stable}, 32'd1);
        tick();

        // misaligned sh passes through with no request
        ex_reg = mk(op_store, 3'b001, 5'd4, 32'h0000_0301, 32'h0000_FFFF, 1'b1);
        #1;
        chk("mis_sh_stall", {31'b0, mem_stall}, 32'd0);
        chk("mis_sh_write", {31'b0, dmem_write}, 32'd0);
        tick();
        chk("mis_sh_load_regfile", {31'b0, mem_reg.load_regfile}, 32'd0);
        chk("mis_sh_alu_out", mem_reg.alu_out, 32'h0000_0301);
        chk("mis_sh_no_req", {30'b0, dmem_read, dmem_write}, 32'd0);

        // misaligned lw
        ex_reg = mk(op_load, 3'b010, 5'd6, 32'h0000_0102, 32'h0, 1'b1);
        #1;
        chk("mis_lw_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        chk("mis_lw_load_regfile", {31'b0, mem_reg.load_regfile}, 32'd0);
        chk("mis_lw_rd", {27'b0, mem_reg.rd}, 32'd6);
        chk("mis_lw_read", {31'b0, dmem_read}, 32'd0);

        // addi then bubble
        ex_reg = mk(op_imm, 3'b000, 5'd5, 32'h0000_0007, 32'h0, 1'b1);
        #1;
        chk("addi_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        chk("addi_rd", {27'b0, mem_reg.rd}, 32'd5);
        chk("addi_alu_out", mem_reg.alu_out, 32'h0000_0007);
        chk("addi_valid", {31'b0, mem_reg.valid}, 32'd1);
        chk("addi_load_regfile", {31'b0, mem_reg.load_regfile}, 32'd1);
        ex_reg.valid = 1'b0;
        #1;
        tick();
        chk("bubble_valid", {31'b0, mem_reg.valid}, 32'd0);
        chk("bubble_no_req", {30'b0, dmem_read, dmem_write}, 32'd0);

        // reset during BUSY, late response ignored
        ex_reg = mk(op_load, 3'b010, 5'd7, 32'h0000_0100, 32'h0, 1'b1);
        #1;
        chk("abort_idle_stall", {31'b0, mem_stall}, 32'd1);
        tick();
        chk("abort_busy_read", {31'b0, dmem_read}, 32'd1);
        rst = 1'b0;
        ex_reg.valid = 1'b0;
        #1;
        tick();
        chk("abort_read_dropped", {31'b0, dmem_read}, 32'd0);
        chk("abort_stall", {31'b0, mem_stall}, 32'd0);
        chk("abort_mem_reg_valid", {31'b0, mem_reg.valid}, 32'd0);
        rst        = 1'b1;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h0BAD_0BAD;
        #1;
        chk("late_resp_read", {31'b0, dmem_read}, 32'd0);
        tick();
        dmem_resp = 1'b0;
        #1;
        chk("late_resp_valid", {31'b0, mem_reg.valid}, 32'd0);
        chk("late_resp_idle", {30'b0, dmem_read, mem_stall}, 32'd0);

        // back-to-back loads
        ex_reg = mk(op_load, 3'b010, 5'd1, 32'h0000_0400, 32'h0, 1'b1);
        #1;
        run_access(1, 32'h1111_1111, rd_cnt, wr_cnt, st_cnt, a_addr, a_wdata, a_mbe, a_stable);
        chk("b2b1_read_cycles", rd_cnt, 32'd1);
        chk("b2b1_stall_cycles", st_cnt, 32'd2);
        tick();
        chk("b2b1_mem_rdata", mem_reg.mem_rdata, 32'h1111_1111);
        chk("b2b1_rd", {27'b0, mem_reg.rd}, 32'd1);
        ex_reg = mk(op_load, 3'b010, 5'd2, 32'h0000_0404, 32'h0, 1'b1);
        #1;
        chk("b2b_idle_gap_read", {31'b0, dmem_read}, 32'd0);
        chk("b2b_idle_gap_stall", {31'b0, mem_stall}, 32'd1);
        run_access(1, 32'h2222_2222, rd_cnt, wr_cnt, st_cnt, a_addr, a_wdata, a_mbe, a_stable);
        chk("b2b2_read_cycles", rd_cnt, 32'd1);
        chk("b2b2_addr", a_addr, 32'h0000_0404);
        tick();
        chk("b2b2_mem_rdata", mem_reg.mem_rdata, 32'h2222_2222);
        chk("b2b2_rd", {27'b0, mem_reg.rd}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
